mux_sel_arbiter8: RTL and testbench
===================================

Name: mux_sel_arbiter8

Overview:
- Round-robin arbiter that shares one 8:1 selection datapath (the mux8_1 instance on a shared bus) between 8 requesters.
- Drives the mux select with the winner's index and a one-hot grant back to the requesters.
- Holds ownership until the owner finishes, drops its request, or exceeds a hold limit.
- Sits between requesting units and the shared mux; `sel` connects directly to the mux select.

Parameters:
- HOLD_MAX, 16: maximum consecutive cycles one owner may hold the grant; 0 disables the limit.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  8  request vector; bit i = requester i wants the mux.
- done  in  1  owner signals its transfer is complete this cycle; ignored when not busy.
- grant  out  8  one-hot grant, all-zero when idle.
- sel  out  3  mux select = index of current or last owner.
- busy  out  1  high while some requester owns the mux.
- timeout  out  1  one-cycle pulse when an owner is forcibly released by HOLD_MAX.

Behaviour:
- Single clock; reset is synchronous and active-high, using ports clk and reset.
- All outputs registered. Reset values: grant=0, sel=0, busy=0, timeout=0; internal priority pointer ptr=0, hold counter cnt=0, state=IDLE.
- Reset asserted mid-ownership wins over everything: the next edge returns all state to reset values, with no timeout pulse.
- States are IDLE and OWNED.
- Pick function: scan indices ptr, ptr+1, ..., ptr+7 (mod 8). The first index with req set wins. Index arithmetic is 3-bit and wraps 7->0.
- IDLE:
  - If req != 0: next edge sets grant to the winner's one-hot, sel = winner, busy=1, cnt=0, state=OWNED. Latency from req to grant is 1 cycle.
  - If req == 0: stay IDLE; grant=0, busy=0, sel holds its previous value.
- OWNED, owner o:
  - cnt increments each cycle, saturating at HOLD_MAX.
  - Release condition, evaluated each cycle: done=1, OR req[o]=0, OR (HOLD_MAX != 0 AND cnt == HOLD_MAX-1).
  - On release, ptr <= o+1 (mod 8) and re-arbitration happens in the same cycle using that new ptr.
    - If a winner exists, the next edge grants it directly: no idle bubble, cnt=0, stay OWNED.
    - o itself may win only if no other req bit is set.
    - If no winner exists, the next edge goes to IDLE: grant=0, busy=0, sel unchanged.
  - With no release, grant, sel and ptr are unchanged.
- timeout:
  - Asserted for exactly the cycle after release, only when the release was caused solely by the hold limit (done=0 and req[o]=1).
  - done on the limit cycle is a normal release, with no timeout pulse.
- HOLD_MAX=1: every grant lasts one cycle, giving pure per-cycle round-robin; timeout pulses whenever the owner still requests and done=0.
- Invariants: grant is always zero or one-hot. When busy=1, grant[sel]=1. busy == |grant.

Decomposition:
- Shared package mux_arb_pkg:
  - NREQ=8, SEL_W=3.
  - typedef enum logic {IDLE, OWNED} arb_state_t.
  - typedef logic [SEL_W-1:0] req_idx_t.
- One combinational sub-module, rr_pick8:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - Implemented as rotate-then-priority-encode.
- The top level holds the state register, ptr, cnt and the output registers.

Test Plan:
- Reset, then req=8'b0010_0100 with ptr=0 -> 1 cycle later grant=8'b0000_0100, sel=2, busy=1.
- That owner pulses done while req[5] is still set -> next cycle grant=8'b0010_0000, sel=5, no idle cycle, ptr=3 at the handoff.
- All 8 requesting continuously, done pulsed every 2nd owned cycle -> sel sequence 0,1,2,...,7,0 with no index skipped or repeated.
- HOLD_MAX=4, single owner 3 with req held and done=0 while req[6]=1 -> grant moves to 6 after 4 owned cycles; timeout high for exactly 1 cycle.
- Owner drops req with no other requesters -> next cycle grant=0, busy=0, sel keeps its previous value.
- Assert reset while OWNED, with done and the limit coinciding on a prior run -> next cycle all outputs 0; later grant resumes from ptr=0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and sizes for the 8-way mux select arbiter
package mux_arb_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, OWNED} arb_state_t;

  typedef logic [SEL_W-1:0] req_idx_t;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - round-robin pick: first set request scanning from ptr upward, wrapping 7->0
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_idx_t        ptr,
  output logic            found,
  output req_idx_t        idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  req_idx_t          off;

  // rot[k] = req[(ptr + k) mod 8], so the lowest set bit is the next in turn
  assign dbl = {req, req};
  assign rot = dbl[{1'b0, ptr} +: NREQ];

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = req_idx_t'(i);
    end
  end

  assign found = |req;
  assign idx   = req_idx_t'(ptr + off);

endmodule

// File: rtl/mux_sel_arbiter8.sv
// rtl/mux_sel_arbiter8.sv - round-robin owner arbiter driving a shared 8:1 mux select and one-hot grant
module mux_sel_arbiter8
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  arb_state_t       state, state_d;
  req_idx_t         ptr, pick_ptr, win_idx;
  logic             win_found;
  logic [CNT_W-1:0] cnt;
  logic             owner_req, at_limit, release_now;
  logic [7:0]       grant_d;
  logic [2:0]       sel_d;
  logic             busy_d, timeout_d;

  // While owned, sel is the owner, so re-arbitration starts just past it
  assign owner_req   = req[sel];
  assign at_limit    = (HOLD_MAX != 0) && (cnt == LIMIT);
  assign release_now = (state == OWNED) && (done || !owner_req || at_limit);
  assign pick_ptr    = (state == OWNED) ? req_idx_t'(sel + 3'd1) : ptr;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (win_found),
    .idx   (win_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      sel     <= sel_d;
      busy    <= busy_d;
      timeout <= timeout_d;
      if (release_now) ptr <= pick_ptr;
      if (state == IDLE || release_now) cnt <= '0;
      else if (cnt != CNT_MAX)          cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (win_found) state_d = OWNED;
      OWNED:   if (release_now && !win_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant;
    sel_d     = sel;
    busy_d    = busy;
    timeout_d = release_now && at_limit && !done && owner_req;
    if (state == IDLE || release_now) begin
      grant_d = '0;
      busy_d  = win_found;
      if (win_found) begin
        grant_d[win_idx] = 1'b1;
        sel_d            = win_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter8.sv
// tb/tb_mux_sel_arbiter8.sv - scoreboard bench for mux_sel_arbiter8 with HOLD_MAX=4
module tb_mux_sel_arbiter8;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  mux_sel_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({grant, sel, busy, timeout} !== e) begin
        fails++;
        $display("FAIL cyc%0d outputs: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                 cyc, grant, sel, busy, timeout, e.g, e.s, e.b, e.t);
      end
    end
  end

  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] eg, input logic [2:0] es, input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    reset = r;
    req   = rq;
    done  = d;
    e.g = eg; e.s = es; e.b = eb; e.t = et;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] oh;
    // reset state
    step(1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    step(1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    // first grant from ptr=0, then done hands off to 5 with no bubble
    step(0, 8'b0010_0100, 0, 8'b0000_0100, 3'd2, 1, 0);
    step(0, 8'b0010_0100, 1, 8'b0010_0000, 3'd5, 1, 0);
    step(0, 8'b0010_0000, 0, 8'b0010_0000, 3'd5, 1, 0);
    // owner drops with nobody else: idle, sel holds
    step(0, 8'b0000_0000, 0, 8'h00, 3'd5, 0, 0);
    step(0, 8'b0000_0000, 0, 8'h00, 3'd5, 0, 0);
    // owner 3 held to the limit while 6 waits
    step(0, 8'b0000_1000, 0, 8'b0000_1000, 3'd3, 1, 0);
    step(0, 8'b0100_1000, 0, 8'b0000_1000, 3'd3, 1, 0);
    step(0, 8'b0100_1000, 0, 8'b0000_1000, 3'd3, 1, 0);
    step(0, 8'b0100_1000, 0, 8'b0000_1000, 3'd3, 1, 0);
    step(0, 8'b0100_1000, 0, 8'b0100_0000, 3'd6, 1, 1);
    step(0, 8'b0100_0000, 0, 8'b0100_0000, 3'd6, 1, 0);
    step(0, 8'b0100_0000, 0, 8'b0100_0000, 3'd6, 1, 0);
    step(0, 8'b0100_0000, 0, 8'b0100_0000, 3'd6, 1, 0);
    // done coincides with the limit: normal release, sole requester regains it
    step(0, 8'b0100_0000, 1, 8'b0100_0000, 3'd6, 1, 0);
    // reset mid-ownership, then resume from ptr=0
    step(1, 8'b0100_0000, 0, 8'h00, 3'd0, 0, 0);
    step(0, 8'hFF, 0, 8'b0000_0001, 3'd0, 1, 0);
    // all requesting, done every second owned cycle
    for (int i = 1; i <= 8; i++) begin
      oh = 8'd1 << (i - 1);
      step(0, 8'hFF, 0, oh, 3'(i - 1), 1, 0);
      oh = 8'd1 << (i % 8);
      step(0, 8'hFF, 1, oh, 3'(i % 8), 1, 0);
    end
    // all requesting, no done: limit forces 0 -> 1 with a timeout pulse
    step(0, 8'hFF, 0, 8'b0000_0001, 3'd0, 1, 0);
    step(0, 8'hFF, 0, 8'b0000_0001, 3'd0, 1, 0);
    step(0, 8'hFF, 0, 8'b0000_0001, 3'd0, 1, 0);
    step(0, 8'hFF, 0, 8'b0000_0010, 3'd1, 1, 1);
    step(0, 8'h00, 0, 8'h00, 3'd1, 0, 0);
    step(0, 8'h00, 0, 8'h00, 3'd1, 0, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
